// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcode encoding and the requester count used by
// the arbiter and the instruction decoder.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = $clog2(NUM_REQ);

  // ALU opcodes. LUI and SLL ignore aluc[0]; the canonical encodings are listed.
  typedef enum logic [3:0] {
    ALUC_ADDU = 4'b0000,
    ALUC_SUBU = 4'b0001,
    ALUC_ADD  = 4'b0010,
    ALUC_SUB  = 4'b0011,
    ALUC_AND  = 4'b0100,
    ALUC_OR   = 4'b0101,
    ALUC_XOR  = 4'b0110,
    ALUC_NOR  = 4'b0111,
    ALUC_LUI  = 4'b1000,
    ALUC_SLTU = 4'b1010,
    ALUC_SLT  = 4'b1011,
    ALUC_SRA  = 4'b1100,
    ALUC_SRL  = 4'b1101,
    ALUC_SLL  = 4'b1110
  } aluc_e;

  // Result plus flags, captured together in the response register.
  typedef struct packed {
    logic [XLEN-1:0] r;
    logic            zero;
    logic            carry;
    logic            negative;
    logic            overflow;
  } alu_res_t;

  // Fold the don't-care LSB of LUI (100x) and SLL (111x) onto one encoding.
  function automatic logic [3:0] aluc_canon(input logic [3:0] aluc);
    if (aluc[3:1] == 3'b100) return ALUC_LUI;
    if (aluc[3:1] == 3'b111) return ALUC_SLL;
    return aluc;
  endfunction

endpackage

// File: rtl/alu.sv
// 32-bit MIPS-style ALU. Shifts move operand b by a[4:0]; carry reports the
// unsigned carry/borrow or the last bit shifted out.
module alu
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      aluc,
  output logic [XLEN-1:0] r,
  output logic            zero,
  output logic            carry,
  output logic            negative,
  output logic            overflow
);

  logic [XLEN:0]   sum_x;
  logic [XLEN:0]   diff_x;
  logic [XLEN:0]   sll_x;
  logic [XLEN:0]   srl_x;
  logic [XLEN:0]   sra_x;
  logic [4:0]      shamt;
  logic            slt;
  logic [3:0]      op;

  assign op     = aluc_canon(aluc);
  assign shamt  = a[4:0];
  assign sum_x  = {1'b0, a} + {1'b0, b};
  assign diff_x = {1'b0, a} - {1'b0, b};
  assign slt    = $signed(a) < $signed(b);
  // One extra bit on the outgoing side of each shift catches the last bit out.
  assign sll_x  = {1'b0, b} << shamt;
  assign srl_x  = {b, 1'b0} >> shamt;
  assign sra_x  = $signed({b, 1'b0}) >>> shamt;

  // Opcode decode and flag generation.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    r        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      ALUC_ADDU: begin r = sum_x[XLEN-1:0];  carry = sum_x[XLEN];  end
      ALUC_SUBU: begin r = diff_x[XLEN-1:0]; carry = diff_x[XLEN]; end
      ALUC_ADD: begin
        r        = sum_x[XLEN-1:0];
        overflow = (a[XLEN-1] == b[XLEN-1]) && (sum_x[XLEN-1] != a[XLEN-1]);
      end
      ALUC_SUB: begin
        r        = diff_x[XLEN-1:0];
        overflow = (a[XLEN-1] != b[XLEN-1]) && (diff_x[XLEN-1] != a[XLEN-1]);
      end
      ALUC_AND:  r = a & b;
      ALUC_OR:   r = a | b;
      ALUC_XOR:  r = a ^ b;
      ALUC_NOR:  r = ~(a | b);
      ALUC_LUI:  r = {b[15:0], 16'h0000};
      ALUC_SLTU: begin r = {{(XLEN-1){1'b0}}, diff_x[XLEN]}; carry = diff_x[XLEN]; end
      ALUC_SLT:  r = {{(XLEN-1){1'b0}}, slt};
      ALUC_SRA:  begin r = sra_x[XLEN:1];   carry = sra_x[0];    end
      ALUC_SRL:  begin r = srl_x[XLEN:1];   carry = srl_x[0];    end
      ALUC_SLL:  begin r = sll_x[XLEN-1:0]; carry = sll_x[XLEN]; end
      default:   r = '0;
    endcase
    zero     = (r == '0);
    // SLT reports the comparison outcome as "negative" (a - b < 0 signed).
    negative = (op == ALUC_SLT) ? slt : r[XLEN-1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end to a single shared ALU. Grants one operation per
// cycle (round-robin or fixed priority) into a one-entry result register.
module alu_arbiter
  import cpu_pkg::*;
#(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_a,
  input  logic [XLEN-1:0]  req0_b,
  input  logic [3:0]       req0_aluc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_a,
  input  logic [XLEN-1:0]  req1_b,
  input  logic [3:0]       req1_aluc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [XLEN-1:0]  rsp_r,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_negative,
  output logic             rsp_overflow,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam logic ROUND_ROBIN = (RR_EN != 0);

  logic            accept_ok;
  logic            prefer1;
  logic            grant0;
  logic            grant1;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      op_aluc;
  logic [XLEN-1:0] alu_r;
  logic            alu_zero;
  logic            alu_carry;
  logic            alu_negative;
  logic            alu_overflow;

  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q,    rsp_id_d;
  alu_res_t        rsp_q,       rsp_d;
  logic [CNT_W-1:0] cnt0_q,     cnt0_d;
  logic [CNT_W-1:0] cnt1_q,     cnt1_d;
  // Index of the requester granted most recently; resets to 1 so requester 0 wins first.
  logic [ID_W-1:0] last_q,      last_d;

  // Grant decision: at most one winner, only when the result slot frees up.
  always_comb begin
    accept_ok = !rst && (!rsp_valid_q || rsp_ready);
    prefer1   = ROUND_ROBIN && (last_q == ID_W'(0));
    grant0    = accept_ok && req0_valid && (!req1_valid || !prefer1);
    grant1    = accept_ok && req1_valid && (!req0_valid || prefer1);
    op_a      = grant1 ? req1_a    : req0_a;
    op_b      = grant1 ? req1_b    : req0_b;
    op_aluc   = grant1 ? req1_aluc : req0_aluc;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  alu u_alu (
    .a        (op_a),
    .b        (op_b),
    .aluc     (op_aluc),
    .r        (alu_r),
    .zero     (alu_zero),
    .carry    (alu_carry),
    .negative (alu_negative),
    .overflow (alu_overflow)
  );

  // Next state of the result register, grant pointer and saturating counters.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_d       = rsp_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    last_d      = last_q;
    if (grant0 || grant1) begin
      // A grant in the drain cycle overwrites the old result with no bubble.
      rsp_valid_d    = 1'b1;
      rsp_id_d       = ID_W'(grant1);
      rsp_d.r        = alu_r;
      rsp_d.zero     = alu_zero;
      rsp_d.carry    = alu_carry;
      rsp_d.negative = alu_negative;
      rsp_d.overflow = alu_overflow;
      last_d         = ID_W'(grant1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (grant0 && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (grant1 && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  // State registers with synchronous reset; reset discards any pending result.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_q       <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      last_q      <= ID_W'(1);
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_q       <= rsp_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      last_q      <= last_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_r        = rsp_q.r;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_carry    = rsp_q.carry;
  assign rsp_negative = rsp_q.negative;
  assign rsp_overflow = rsp_q.overflow;
  assign grant_cnt0   = cnt0_q;
  assign grant_cnt1   = cnt1_q;

endmodule
